// File: rtl/soc_timer_pkg.sv
// Shared register map, control-field layout and status encoding for the
// memory-mapped interval timer.
package soc_timer_pkg;

  localparam logic [1:0] TMR_LO   = 2'd0;
  localparam logic [1:0] TMR_HI   = 2'd1;
  localparam logic [1:0] TMR_CTRL = 2'd2;
  localparam logic [1:0] TMR_STAT = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CONT     = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_PSEL_LSB = 3;
  localparam int CTRL_PSEL_MSB = 5;
  localparam int STAT_FLAG     = 7;

  // Packed so that the field order matches the ctrl byte bit positions.
  typedef struct packed {
    logic [2:0] psel;
    logic       ie;
    logic       cont;
    logic       en;
  } ctrl_t;

  function automatic logic [7:0] stat_byte(input logic flag, input logic en);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_FLAG] = flag;
    s[CTRL_EN]   = en;
    return s;
  endfunction

endpackage

// File: rtl/soc_timer_if.sv
// CPU-side bus of the timer: chip select, write strobe, register select,
// write/read data and the level interrupt.
interface soc_timer_if;
  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport slave  (input cs, we, rs, din, output dout, irq);
  modport master (output cs, we, rs, din, input dout, irq);
endinterface

// File: rtl/soc_timer_prescaler.sv
// Power-of-two clock divider: emits a one-cycle tick every 2^psel enabled
// clocks; frozen while en is low, restarted by clr.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] psel,
  output logic       tick
);

  logic [PRE_W-1:0] pre_q, pre_d, mask;

  always_comb begin
    mask  = (PRE_W'(1) << psel) - PRE_W'(1);
    tick  = en && ((pre_q & mask) == mask);
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/soc_timer.sv
// 16-bit programmable interval timer on the 6502 SoC bus: reload register,
// down-counter, prescaler, sticky underflow flag and registered level IRQ.
module soc_timer
  import soc_timer_pkg::*;
#(
  parameter int          PRE_W   = 8,
  parameter logic [15:0] RST_RLD = 16'hFFFF
) (
  input logic        clk,
  input logic        reset,
  soc_timer_if.slave bus
);

  logic [15:0] cnt_q, cnt_d, rld_q, rld_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        flag_q, flag_d, irq_q, irq_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d, dout_q, dout_d;
  logic        wr, rd, tick, underflow;

  assign wr = bus.cs & bus.we;
  assign rd = bus.cs & ~bus.we;

  timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .clr   (wr && bus.rs == TMR_HI),
    .psel  (ctrl_q.psel),
    .tick  (tick)
  );

  always_comb begin
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    ctrl_d    = ctrl_q;
    flag_d    = flag_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    underflow = 1'b0;

    // A high-byte write commits the 16-bit value and suppresses that tick.
    if (wr && bus.rs == TMR_HI) begin
      cnt_d = {bus.din, lo_q};
      rld_d = {bus.din, lo_q};
    end else if (tick) begin
      if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        underflow = 1'b1;
        if (ctrl_q.cont) cnt_d = rld_q;
        else             ctrl_d.en = 1'b0;
      end
    end

    if (wr && bus.rs == TMR_CTRL) ctrl_d = ctrl_t'(bus.din[5:0]);

    if (underflow) begin
      flag_d = 1'b1;
    end else if ((rd && bus.rs == TMR_STAT) ||
                 (wr && bus.rs == TMR_STAT && bus.din[STAT_FLAG])) begin
      flag_d = 1'b0;
    end

    if (wr && bus.rs == TMR_LO) lo_d = bus.din;
    // Latching the high byte with the low-byte read keeps 16-bit reads atomic.
    if (rd && bus.rs == TMR_LO) hi_d = cnt_q[15:8];

    unique case (bus.rs)
      TMR_LO:   dout_d = cnt_q[7:0];
      TMR_HI:   dout_d = hi_q;
      TMR_CTRL: dout_d = {2'b00, ctrl_q};
      default:  dout_d = stat_byte(flag_q, ctrl_q.en);
    endcase

    irq_d = flag_q & ctrl_q.ie;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      rld_q  <= RST_RLD;
      ctrl_q <= '0;
      flag_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      dout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      ctrl_q <= ctrl_d;
      flag_q <= flag_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      dout_q <= dout_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = irq_q;

endmodule
